uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT SHALL default to 50000 and set the escape-sequence idle timeout in clk cycles; the legal range is 2..65535.
REQ-002 Port clk SHALL be an input, 1 bit: the system clock; all logic is rising-edge.
REQ-003 Port rst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 Port i_rx_data SHALL be an input, 8 bits: a received UART byte, valid only when i_rx_valid=1.
REQ-005 Port i_rx_valid SHALL be an input, 1 bit: a one-cycle strobe marking a new byte on i_rx_data.
REQ-006 Port o_dir SHALL be an output, 3 bits: direction code, 0 up, 1 right, 2 down, 3 left, 4 no input.
REQ-007 Port o_restart SHALL be an output, 1 bit: a one-cycle game-restart pulse.
REQ-008 Port o_err_count SHALL be an output, 8 bits: saturating count of rejected bytes and sequences.
REQ-009 Port o_seq_busy SHALL be an output, 1 bit: high while an escape sequence is partially received.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, ESC (0x1B received) and CSI (0x1B 0x5B received).
REQ-011 In IDLE, single-byte commands SHALL map as follows, upper and lower case alike:
- 'w' (0x77/0x57) -> o_dir=0
- 'd' (0x64/0x44) -> o_dir=1
- 's' (0x73/0x53) -> o_dir=2
- 'a' (0x61/0x41) -> o_dir=3
- 'r' (0x72/0x52) -> o_restart=1
REQ-012 In IDLE, byte 0x1B SHALL move the FSM to ESC with no output.
REQ-013 In IDLE, bytes 0x0D, 0x0A and 0x20 SHALL be ignored silently; any other byte SHALL increment o_err_count.
REQ-014 In ESC, 0x5B SHALL move the FSM to CSI.
REQ-015 In ESC, 0x1B SHALL keep the FSM in ESC and restart the timeout.
REQ-016 In ESC, any other byte SHALL return the FSM to IDLE, increment o_err_count, and not be reinterpreted as a command.
REQ-017 In CSI, the final byte SHALL map 0x41->0, 0x43->1, 0x42->2, 0x44->3 on o_dir, then return to IDLE.
REQ-018 In CSI, any other byte SHALL return the FSM to IDLE and increment o_err_count.
REQ-019 Outputs SHALL be registered: o_dir/o_restart are asserted in the cycle after the i_rx_valid cycle, for exactly one cycle.
REQ-020 o_dir SHALL read 4 whenever no direction pulse is active; o_dir≠4 and o_restart=1 SHALL never occur in the same cycle.
REQ-021 The timeout counter SHALL reset to 0 on every accepted byte and increment each cycle while the FSM is in ESC or CSI.
REQ-022 When the timeout counter reaches TIMEOUT-1 with no i_rx_valid, the FSM SHALL return to IDLE next cycle, incrementing o_err_count.
REQ-023 If i_rx_valid arrives on the timeout cycle itself, the byte SHALL take priority: it is decoded normally and no timeout error is counted.
REQ-024 o_err_count SHALL saturate at 255 and never wrap.
REQ-025 o_seq_busy SHALL equal 1 exactly when the FSM is in ESC or CSI.
REQ-026 i_rx_valid held high for consecutive cycles SHALL be treated as one byte per cycle, with no byte dropped.

Reset
REQ-027 On rst=0, asynchronously: FSM=IDLE, o_dir=4, o_restart=0, o_err_count=0, o_seq_busy=0, timeout counter=0.
REQ-028 A reset asserted mid-sequence SHALL discard the partial sequence without counting an error.
REQ-029 After rst returns to 1, the first byte SHALL be decodable on the first rising edge.

Verification
REQ-030 Bytes 'w','D','s','a', each strobed one cycle, 10 cycles apart -> o_dir pulses 0,1,2,3 one cycle after each strobe; o_dir=4 otherwise.
REQ-031 Bytes 0x1B,0x5B,0x43 on consecutive cycles -> o_seq_busy=1 for 2 cycles, then o_dir=1 for one cycle, o_err_count=0.
REQ-032 With TIMEOUT=8: byte 0x1B, then idle 20 cycles -> FSM back in IDLE 8 cycles after the strobe, o_err_count=1, o_dir stays 4.
REQ-033 Bytes 'R' then 'x' then 0x0D -> o_restart pulses once, o_err_count=1 (0x0D ignored).
REQ-034 300 bytes of 'q' -> o_err_count=255 and holds at 255.
REQ-035 Bytes 0x1B,0x5B, then rst=0 for 3 cycles, then 'A' -> no error, o_dir=3 after 'A'.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received bytes (WASD, R, ANSI arrow-key
// escape sequences) into one-cycle direction / restart pulses, counts
// rejected input, and abandons stalled escape sequences after TIMEOUT cycles.
module uart_cmd_decoder #(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic [2:0] o_dir,
   output logic       o_restart,
   output logic [7:0] o_err_count,
   output logic       o_seq_busy
);

   // state | meaning
   // IDLE  | waiting for a single-byte command or an escape byte
   // ESC   | 0x1B received, expecting '[' (0x5B)
   // CSI   | 0x1B 0x5B received, expecting the arrow final byte
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ESC  = 2'd1,
      CSI  = 2'd2
   } state_t;

   localparam logic [2:0]  DIR_UP    = 3'd0;
   localparam logic [2:0]  DIR_RIGHT = 3'd1;
   localparam logic [2:0]  DIR_DOWN  = 3'd2;
   localparam logic [2:0]  DIR_LEFT  = 3'd3;
   localparam logic [2:0]  DIR_NONE  = 3'd4;

   localparam logic [7:0]  BYTE_ESC  = 8'h1B;
   localparam logic [7:0]  BYTE_CSI  = 8'h5B;

   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] tmo_cnt;

   // Single-byte commands, case-insensitive; DIR_NONE when not a direction.
   function automatic logic [2:0] idle_dir(input logic [7:0] b);
      logic [2:0] d;
      d = DIR_NONE;
      case (b)
         8'h77, 8'h57: d = DIR_UP;
         8'h64, 8'h44: d = DIR_RIGHT;
         8'h73, 8'h53: d = DIR_DOWN;
         8'h61, 8'h41: d = DIR_LEFT;
         default:      d = DIR_NONE;
      endcase
      return d;
   endfunction

   // Arrow-key final bytes of ESC [ x; DIR_NONE when not an arrow.
   function automatic logic [2:0] csi_dir(input logic [7:0] b);
      logic [2:0] d;
      d = DIR_NONE;
      case (b)
         8'h41:   d = DIR_UP;
         8'h43:   d = DIR_RIGHT;
         8'h42:   d = DIR_DOWN;
         8'h44:   d = DIR_LEFT;
         default: d = DIR_NONE;
      endcase
      return d;
   endfunction

   function automatic logic is_restart(input logic [7:0] b);
      return (b == 8'h72) || (b == 8'h52);
   endfunction

   // CR, LF and space arrive from terminals routinely and are not errors.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Decoder FSM with registered pulse outputs, error counter and timeout.
   // A received byte always wins over a timeout landing on the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         o_dir       <= DIR_NONE;
         o_restart   <= 1'b0;
         o_err_count <= 8'd0;
         o_seq_busy  <= 1'b0;
         tmo_cnt     <= 16'd0;
      end else begin
         o_dir     <= DIR_NONE;
         o_restart <= 1'b0;
         if (i_rx_valid) begin
            tmo_cnt <= 16'd0;
            case (state)
               IDLE: begin
                  if (i_rx_data == BYTE_ESC) begin
                     state      <= ESC;
                     o_seq_busy <= 1'b1;
                  end else if (idle_dir(i_rx_data) != DIR_NONE) begin
                     o_dir <= idle_dir(i_rx_data);
                  end else if (is_restart(i_rx_data)) begin
                     o_restart <= 1'b1;
                  end else if (!is_ignored(i_rx_data)) begin
                     o_err_count <= sat_inc(o_err_count);
                  end
               end
               ESC: begin
                  if (i_rx_data == BYTE_CSI) begin
                     state      <= CSI;
                     o_seq_busy <= 1'b1;
                  end else if (i_rx_data == BYTE_ESC) begin
                     state      <= ESC;
                     o_seq_busy <= 1'b1;
                  end else begin
                     state       <= IDLE;
                     o_seq_busy  <= 1'b0;
                     o_err_count <= sat_inc(o_err_count);
                  end
               end
               CSI: begin
                  state      <= IDLE;
                  o_seq_busy <= 1'b0;
                  if (csi_dir(i_rx_data) != DIR_NONE) begin
                     o_dir <= csi_dir(i_rx_data);
                  end else begin
                     o_err_count <= sat_inc(o_err_count);
                  end
               end
               default: begin
                  state      <= IDLE;
                  o_seq_busy <= 1'b0;
               end
            endcase
         end else if (state != IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
               state       <= IDLE;
               o_seq_busy  <= 1'b0;
               tmo_cnt     <= 16'd0;
               o_err_count <= sat_inc(o_err_count);
            end else begin
               tmo_cnt <= tmo_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder, built with a short timeout (8 cycles)
// so the escape-sequence expiry paths can be exercised quickly.
module tb_uart_cmd_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic [2:0] o_dir;
   logic       o_restart;
   logic [7:0] o_err_count;
   logic       o_seq_busy;

   int errors = 0;
   int checks = 0;

   uart_cmd_decoder #(.TIMEOUT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_dir       (o_dir),
      .o_restart   (o_restart),
      .o_err_count (o_err_count),
      .o_seq_busy  (o_seq_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte for exactly one sampling edge; back-to-back calls keep
   // i_rx_valid continuously high.
   task automatic send(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   logic [7:0] wasd_bytes [4];
   logic [2:0] wasd_dirs  [4];

   initial begin
      rst        = 1'b0;
      i_rx_data  = 8'h00;
      i_rx_valid = 1'b0;
      wasd_bytes = '{8'h77, 8'h44, 8'h73, 8'h61};
      wasd_dirs  = '{3'd0, 3'd1, 3'd2, 3'd3};

      tick();
      tick();
      chk("reset_dir",     16'(o_dir),       16'd4);
      chk("reset_restart", 16'(o_restart),   16'd0);
      chk("reset_err",     16'(o_err_count), 16'd0);
      chk("reset_busy",    16'(o_seq_busy),  16'd0);

      // first byte decoded on the first edge after reset release
      rst = 1'b1;
      send(8'h77);
      chk("first_byte_dir", 16'(o_dir), 16'd0);
      tick();
      chk("first_byte_idle", 16'(o_dir), 16'd4);

      // w D s a, ten cycles apart
      for (int i = 0; i < 4; i++) begin
         send(wasd_bytes[i]);
         chk("wasd_dir", 16'(o_dir), 16'(wasd_dirs[i]));
         chk("wasd_restart", 16'(o_restart), 16'd0);
         for (int j = 0; j < 9; j++) begin
            tick();
            chk("wasd_gap_dir", 16'(o_dir), 16'd4);
         end
      end

      // ESC [ C on consecutive cycles
      send(8'h1B);
      chk("csi_busy1", 16'(o_seq_busy), 16'd1);
      chk("csi_nodir1", 16'(o_dir), 16'd4);
      send(8'h5B);
      chk("csi_busy2", 16'(o_seq_busy), 16'd1);
      chk("csi_nodir2", 16'(o_dir), 16'd4);
      send(8'h43);
      chk("csi_dir", 16'(o_dir), 16'd1);
      chk("csi_busy_done", 16'(o_seq_busy), 16'd0);
      chk("csi_err", 16'(o_err_count), 16'd0);
      tick();
      chk("csi_dir_after", 16'(o_dir), 16'd4);

      // continuous valid: one byte per cycle, none dropped
      send(8'h64);
      chk("b2b_d", 16'(o_dir), 16'd1);
      send(8'h53);
      chk("b2b_s", 16'(o_dir), 16'd2);
      send(8'h57);
      chk("b2b_w", 16'(o_dir), 16'd0);
      tick();

      // ESC then silence: back to IDLE 8 cycles after the strobe
      send(8'h1B);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("tmo_still_busy", 16'(o_seq_busy), 16'd1);
      end
      tick();
      chk("tmo_idle", 16'(o_seq_busy), 16'd0);
      chk("tmo_err", 16'(o_err_count), 16'd1);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("tmo_dir_quiet", 16'(o_dir), 16'd4);
      end
      chk("tmo_err_hold", 16'(o_err_count), 16'd1);

      // byte on the exact timeout cycle takes priority
      send(8'h1B);
      repeat (7) tick();
      send(8'h5B);
      chk("tmo_race_busy", 16'(o_seq_busy), 16'd1);
      chk("tmo_race_err", 16'(o_err_count), 16'd1);
      send(8'h42);
      chk("tmo_race_dir", 16'(o_dir), 16'd2);
      chk("tmo_race_err2", 16'(o_err_count), 16'd1);

      // repeated ESC restarts the timeout
      send(8'h1B);
      repeat (5) tick();
      send(8'h1B);
      repeat (7) tick();
      chk("esc_rearm_busy", 16'(o_seq_busy), 16'd1);
      chk("esc_rearm_err", 16'(o_err_count), 16'd1);
      tick();
      chk("esc_rearm_idle", 16'(o_seq_busy), 16'd0);
      chk("esc_rearm_err2", 16'(o_err_count), 16'd2);

      // R, x, CR
      send(8'h52);
      chk("restart_pulse", 16'(o_restart), 16'd1);
      chk("restart_dir", 16'(o_dir), 16'd4);
      send(8'h78);
      chk("restart_once", 16'(o_restart), 16'd0);
      chk("bad_byte_err", 16'(o_err_count), 16'd3);
      send(8'h0D);
      chk("cr_ignored", 16'(o_err_count), 16'd3);
      chk("cr_no_restart", 16'(o_restart), 16'd0);

      // ESC followed by a command byte is an error, not a command
      send(8'h1B);
      send(8'h77);
      chk("esc_bad_dir", 16'(o_dir), 16'd4);
      chk("esc_bad_err", 16'(o_err_count), 16'd4);
      chk("esc_bad_idle", 16'(o_seq_busy), 16'd0);

      // bad final byte inside CSI
      send(8'h1B);
      send(8'h5B);
      send(8'h35);
      chk("csi_bad_dir", 16'(o_dir), 16'd4);
      chk("csi_bad_err", 16'(o_err_count), 16'd5);
      chk("csi_bad_idle", 16'(o_seq_busy), 16'd0);

      // reset mid-sequence, asserted between edges
      send(8'h1B);
      send(8'h5B);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_busy", 16'(o_seq_busy), 16'd0);
      chk("async_rst_err", 16'(o_err_count), 16'd0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      send(8'h41);
      chk("post_rst_dir", 16'(o_dir), 16'd3);
      chk("post_rst_err", 16'(o_err_count), 16'd0);
      chk("post_rst_busy", 16'(o_seq_busy), 16'd0);

      // error counter saturation
      for (int n = 1; n <= 300; n++) begin
         send(8'h71);
         if (n == 254) chk("sat_254", 16'(o_err_count), 16'd254);
         if (n == 255) chk("sat_255", 16'(o_err_count), 16'd255);
      end
      chk("sat_hold", 16'(o_err_count), 16'd255);
      tick();
      chk("sat_hold_idle", 16'(o_err_count), 16'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
